// File: rtl/fifo_ctrl_pkg.sv
// Shared widths, count type and default watermark levels for the FIFO controller.
// Watermark levels are only consumed when FIFO_CTRL_WATERMARK_EN is defined.
package fifo_ctrl_pkg;

  localparam int unsigned DEPTH_LOG2_DFLT = 8;
  localparam int unsigned PTR_W           = DEPTH_LOG2_DFLT;
  localparam int unsigned CNT_W           = DEPTH_LOG2_DFLT + 1;
  localparam int unsigned DEPTH           = 1 << DEPTH_LOG2_DFLT;

  localparam int unsigned AF_LEVEL_DFLT = 240;
  localparam int unsigned AE_LEVEL_DFLT = 16;

  typedef logic [CNT_W-1:0] count_t;

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int unsigned cnt_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
module fifo_ctrl_ptr #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q + Width'(inc_i);
    if (clr_i) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Occupancy/pointer controller for the FIFO storage: push/pop acceptance, count, status, errors.
// Define FIFO_CTRL_WATERMARK_EN to add registered almost_full/almost_empty flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DFLT
`ifdef FIFO_CTRL_WATERMARK_EN
  ,
  parameter int unsigned AF_LEVEL = AF_LEVEL_DFLT,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DFLT
`endif
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  flush,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_waddr,
  output logic                  mem_re,
  output logic [DEPTH_LOG2-1:0] mem_raddr,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf
`ifdef FIFO_CTRL_WATERMARK_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int unsigned CntW = cnt_w(DEPTH_LOG2);
  localparam logic [CntW-1:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [CntW-1:0] count_d, count_q;
  logic            ovf_d, ovf_q;
  logic            unf_d, unf_q;
  logic            rd_valid_d, rd_valid_q;

  always_comb begin
    full   = (count_q == DepthCnt);
    empty  = (count_q == '0);
    wr_ack = wr_req & ~full & ~flush;
    rd_ack = rd_req & ~empty & ~flush;

    count_d    = count_q + CntW'(wr_ack) - CntW'(rd_ack);
    ovf_d      = ovf_q | (wr_req & full);
    unf_d      = unf_q | (rd_req & empty);
    rd_valid_d = rd_ack;
    // Flush wins over every other update, including the error flags.
    if (flush) begin
      count_d    = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ctrl_ptr #(
    .Width (DEPTH_LOG2)
  ) u_wptr (
    .clk_i (CLK),
    .rst_i (ARST),
    .clr_i (flush),
    .inc_i (wr_ack),
    .ptr_o (mem_waddr)
  );

  fifo_ctrl_ptr #(
    .Width (DEPTH_LOG2)
  ) u_rptr (
    .clk_i (CLK),
    .rst_i (ARST),
    .clr_i (flush),
    .inc_i (rd_ack),
    .ptr_o (mem_raddr)
  );

  assign mem_we   = wr_ack;
  assign mem_re   = rd_ack;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign rd_valid = rd_valid_q;

`ifdef FIFO_CTRL_WATERMARK_EN
  localparam logic [CntW-1:0] AfCnt = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeCnt = CntW'(AE_LEVEL);

  logic af_d, af_q;
  logic ae_d, ae_q;

  // Compare against next count so the flags line up with the registered count.
  always_comb begin
    af_d = (count_d >= AfCnt);
    ae_d = (count_d <= AeCnt);
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= af_d;
      ae_q <= ae_d;
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`endif

endmodule
